store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
Posted-write buffer between the CPU's data-memory port and a slow, handshaked data memory. CPU stores enter a DEPTH-entry FIFO and retire to memory in the background. CPU loads are forwarded from the buffer on an address hit, or issued to memory on a miss with the CPU stalled. It provides the stall that lets the single-cycle core run against multi-cycle memory.

Parameters:
n, 16, data and address width (matches the CPU word size)
DEPTH, 4, buffer entries (power of two, at least 2)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
cpu_memwrite  input  1  CPU store request this cycle
cpu_memread  input  1  CPU load request this cycle
cpu_addr  input  n  load/store address (CPU aluout)
cpu_wdata  input  n  store data (CPU writedata)
cpu_rdata  output  n  load data to CPU (CPU readdata)
stall  output  1  CPU must hold pc and all inputs this cycle
mem_req  output  1  memory transaction request
mem_we  output  1  1 = write, 0 = read; valid while mem_req
mem_addr  output  n  memory address; valid while mem_req
mem_wdata  output  n  memory write data; valid while mem_req
mem_rdata  input  n  memory read data; valid with mem_ack on a read
mem_ack  input  1  one-cycle completion strobe; ignored when mem_req=0
count  output  $clog2(DEPTH)+1  buffered stores outstanding

Behaviour:
- Reset (reset=0, async):
  - FIFO emptied, count=0, FSM to IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, stall=0.
  - Any in-flight memory transaction is abandoned; a late mem_ack after release is ignored because mem_req=0.
- FIFO:
  - Circular, head/tail pointers wrap modulo DEPTH.
  - full = (count==DEPTH), empty = (count==0).
  - A pop in the same cycle does not free a slot for a push that cycle.
- Store:
  - cpu_memwrite=1 and !full: push {cpu_addr, cpu_wdata} at the clock edge; stall=0 (zero-latency accept).
  - cpu_memwrite=1 and full: stall=1 (combinational); push occurs on the first edge where !full.
  - cpu_memwrite and cpu_memread both 1: treated as a store; the read is ignored.
- Load hit:
  - cpu_memread=1 and any valid entry address == cpu_addr: cpu_rdata = data of the youngest matching entry (combinational), stall=0.
  - Full-width address compare.
- Load miss:
  - stall=1 from the miss cycle until the RDONE cycle, inclusive of the miss cycle, exclusive of RDONE.
- FSM states IDLE, WRITE, READ, RDONE:
  - IDLE: a load miss has priority and goes to READ (mem_req=1, mem_we=0, mem_addr=cpu_addr registered). Otherwise, if !empty, go to WRITE (mem_req=1, mem_we=1, head addr/data). Otherwise stay in IDLE.
  - WRITE: hold mem_req/addr/data stable until mem_ack. On ack: pop head, mem_req=0, go to IDLE. A store that cannot hit memory is never reordered before older stores.
  - READ: hold until mem_ack. On ack: capture mem_rdata into the read register, mem_req=0, go to RDONE.
  - RDONE: cpu_rdata = captured data, stall=0 for exactly this cycle, go to IDLE.
- Ordering rules:
  - Loads may bypass buffered stores only on a miss; a miss implies no address conflict.
  - A load miss that arrives during WRITE waits (stall=1) until the write acks, then IDLE issues it.
- Memory interface:
  - mem_req deasserts for at least one cycle between transactions.
  - mem_ack may arrive in the same cycle after mem_req rises, i.e. a 1-cycle memory.
- count: registered; +1 on push, -1 on pop, unchanged on simultaneous push and pop.
- CPU contract: while stall=1 the CPU holds cpu_memwrite, cpu_memread, cpu_addr and cpu_wdata constant.

Test Plan:
- Reset, then 3 stores 0x0010/0xAAAA, 0x0012/0xBBBB, 0x0014/0xCCCC with mem_ack held off -> stall=0 on every store, count=3, then 3 WRITE transactions in FIFO order once acks flow, count returns to 0.
- Store 0x0020/0x1111 then 0x0020/0x2222, then load 0x0020 before drain -> cpu_rdata=0x2222 in the same cycle, stall=0, no mem read issued.
- Load miss 0x0040 with mem_ack 3 cycles after mem_req, mem_rdata=0x5A5A -> stall=1 through ack, RDONE cycle shows cpu_rdata=0x5A5A with stall=0.
- Fill all 4 entries with mem_ack low, issue a 5th store -> stall=1 and count=4 until the first ack; the 5th store is accepted the next edge and count stays 4.
- Load miss issued while a WRITE is pending -> no mem read until the write acks; the read follows after the one-cycle mem_req gap.
- Assert reset low mid-READ with count=2 -> outputs immediately 0 and count=0; after release a stale mem_ack does nothing and the next store proceeds normally.

Source files
------------

// File: rtl/store_buffer_if.sv
// CPU data-port and memory-port signal bundle for the store buffer.
// slave = buffer side, master = CPU plus memory side.
interface store_buffer_if #(
  parameter int n     = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          cpu_memwrite;
  logic          cpu_memread;
  logic [n-1:0]  cpu_addr;
  logic [n-1:0]  cpu_wdata;
  logic [n-1:0]  cpu_rdata;
  logic          stall;

  logic          mem_req;
  logic          mem_we;
  logic [n-1:0]  mem_addr;
  logic [n-1:0]  mem_wdata;
  logic [n-1:0]  mem_rdata;
  logic          mem_ack;

  logic [CW-1:0] count;

  modport slave (
    input  cpu_memwrite, cpu_memread, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, count
  );

  modport master (
    output cpu_memwrite, cpu_memread, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, count
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer: stores accepted in zero cycles, loads forwarded on hit or fetched on miss.
// Backpressure: stall on store-while-full and from a load miss until the read-data cycle.
module store_buffer #(
  parameter int n     = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RDONE} state_t;

  state_t        state_q, state_d;
  logic [n-1:0]  fifo_addr_q [DEPTH];
  logic [n-1:0]  fifo_addr_d [DEPTH];
  logic [n-1:0]  fifo_data_q [DEPTH];
  logic [n-1:0]  fifo_data_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [n-1:0]  mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [n-1:0]  rdata_q, rdata_d;

  logic          full, empty, is_store, is_load, push, pop;
  logic          hit, miss, stall_c;
  logic [n-1:0]  hit_data, rdata_c;
  logic [AW-1:0] idx;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign is_store = bus.cpu_memwrite;
  assign is_load  = bus.cpu_memread && !bus.cpu_memwrite;
  assign push     = is_store && !full;
  assign miss     = is_load && !hit;

  // Scan oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if (CW'(i) < count_q && fifo_addr_q[idx] == bus.cpu_addr) begin
        hit      = 1'b1;
        hit_data = fifo_data_q[idx];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    pop         = 1'b0;
    stall_c     = 1'b0;
    rdata_c     = (is_load && hit) ? hit_data : '0;
    case (state_q)
      IDLE: begin
        stall_c = (is_store && full) || miss;
        if (miss) begin
          state_d     = READ;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.cpu_addr;
          mem_wdata_d = '0;
        end else if (!empty) begin
          state_d     = WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = fifo_addr_q[head_q];
          mem_wdata_d = fifo_data_q[head_q];
        end
      end
      WRITE: begin
        stall_c = (is_store && full) || miss;
        if (bus.mem_ack) begin
          pop         = 1'b1;
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      end
      READ: begin
        stall_c = 1'b1;
        if (bus.mem_ack) begin
          rdata_d    = bus.mem_rdata;
          state_d    = RDONE;
          mem_req_d  = 1'b0;
          mem_addr_d = '0;
        end
      end
      RDONE: begin
        stall_c = is_store && full;
        rdata_c = rdata_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    if (push) begin
      fifo_addr_d[tail_q] = bus.cpu_addr;
      fifo_data_d[tail_q] = bus.cpu_wdata;
    end
    tail_d  = tail_q + AW'(push);
    head_d  = head_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
    end
  end

  // Combinational outputs are forced quiet while reset is held, even if the CPU is mid-load.
  assign bus.stall     = stall_c && reset;
  assign bus.cpu_rdata = reset ? rdata_c : '0;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_store_buffer.sv
// Directed stimulus for store_buffer with a scoreboard-driven monitor and a latency-programmable memory.
module tb_store_buffer;
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  logic clk;
  logic reset;

  store_buffer_if #(.n(16), .DEPTH(4)) bus ();

  store_buffer #(.n(16), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  txn_t        exp_mem [$];
  logic [15:0] exp_ld  [$];

  int checks;
  int errors;

  // Probes set by the stimulus for the current cycle, compared by the monitor.
  logic        pr_stall_en, pr_stall;
  logic        pr_count_en;
  logic [2:0]  pr_count;
  logic        pr_zero_en;
  logic        done;

  // Memory model controls.
  logic        ack_en;
  int          ack_lat;
  logic [15:0] rd_val;
  logic        stale;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: acks ack_lat cycles after mem_req rises while ack_en is set.
  initial begin
    int age;
    age = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_rdata = rd_val;
      if (stale) begin
        bus.mem_ack = 1'b1;
      end else if (!bus.mem_req) begin
        age = 0;
        bus.mem_ack = 1'b0;
      end else begin
        bus.mem_ack = (ack_en && age >= ack_lat);
        age++;
      end
    end
  end

  // Monitor: sole owner of the check counters.
  initial begin
    txn_t        e;
    logic [15:0] el;
    logic        prev_ack;
    checks   = 0;
    errors   = 0;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (pr_zero_en) begin
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_count", bus.count, 0);
      end
      if (pr_stall_en) chk("stall", bus.stall, pr_stall);
      if (pr_count_en) chk("count", bus.count, pr_count);
      if (prev_ack) chk("req_gap", bus.mem_req, 0);
      if (reset && bus.mem_req && bus.mem_ack) begin
        if (exp_mem.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_txn: got we=%0b addr=%h, expected no transaction", bus.mem_we, bus.mem_addr);
        end else begin
          e = exp_mem.pop_front();
          chk("mem_we", bus.mem_we, e.we);
          chk("mem_addr", bus.mem_addr, e.addr);
          if (e.we) chk("mem_wdata", bus.mem_wdata, e.data);
        end
      end
      if (reset && bus.cpu_memread && !bus.cpu_memwrite && !bus.stall) begin
        if (exp_ld.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL load: got completion rdata=%h, expected none", bus.cpu_rdata);
        end else begin
          el = exp_ld.pop_front();
          chk("cpu_rdata", bus.cpu_rdata, el);
        end
      end
      prev_ack = reset && bus.mem_req && bus.mem_ack;
      if (done) begin
        chk("mem_queue_left", exp_mem.size(), 0);
        chk("load_queue_left", exp_ld.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    pr_stall_en = 1'b0;
    pr_count_en = 1'b0;
    pr_zero_en  = 1'b0;
  endtask

  task automatic cpu_idle();
    bus.cpu_memwrite = 1'b0;
    bus.cpu_memread  = 1'b0;
    bus.cpu_addr     = '0;
    bus.cpu_wdata    = '0;
  endtask

  task automatic cpu_st(input logic [15:0] a, input logic [15:0] d);
    bus.cpu_memwrite = 1'b1;
    bus.cpu_memread  = 1'b0;
    bus.cpu_addr     = a;
    bus.cpu_wdata    = d;
  endtask

  task automatic cpu_ld(input logic [15:0] a);
    bus.cpu_memwrite = 1'b0;
    bus.cpu_memread  = 1'b1;
    bus.cpu_addr     = a;
    bus.cpu_wdata    = '0;
  endtask

  task automatic want_stall(input logic v);
    pr_stall_en = 1'b1;
    pr_stall    = v;
  endtask

  task automatic want_count(input logic [2:0] v);
    pr_count_en = 1'b1;
    pr_count    = v;
  endtask

  task automatic exp_wr(input logic [15:0] a, input logic [15:0] d);
    exp_mem.push_back({1'b1, a, d});
  endtask

  task automatic exp_rd(input logic [15:0] a, input logic [15:0] d);
    exp_mem.push_back({1'b0, a, 16'h0000});
    exp_ld.push_back(d);
  endtask

  initial begin
    reset = 1'b0;
    pr_stall_en = 1'b0; pr_stall = 1'b0;
    pr_count_en = 1'b0; pr_count = '0;
    pr_zero_en = 1'b0; done = 1'b0;
    ack_en = 1'b0; ack_lat = 0; rd_val = '0; stale = 1'b0;
    cpu_idle();
    tick();
    tick(); pr_zero_en = 1'b1;
    tick(); reset = 1'b1;

    // Three posted stores with memory stalled, then drained in order.
    tick(); cpu_st(16'h0010, 16'hAAAA); want_stall(0); exp_wr(16'h0010, 16'hAAAA);
    tick(); cpu_st(16'h0012, 16'hBBBB); want_stall(0); exp_wr(16'h0012, 16'hBBBB);
    tick(); cpu_st(16'h0014, 16'hCCCC); want_stall(0); exp_wr(16'h0014, 16'hCCCC);
    tick(); cpu_idle(); want_count(3); ack_lat = 1; ack_en = 1'b1;
    repeat (15) tick();
    want_count(0);

    // Youngest-match forwarding while the older store is still in flight.
    tick(); ack_en = 1'b0; ack_lat = 0;
    cpu_st(16'h0020, 16'h1111); want_stall(0); exp_wr(16'h0020, 16'h1111);
    tick(); cpu_st(16'h0020, 16'h2222); want_stall(0); exp_wr(16'h0020, 16'h2222);
    tick(); cpu_ld(16'h0020); want_stall(0); exp_ld.push_back(16'h2222);
    tick(); cpu_idle(); ack_en = 1'b1;
    repeat (10) tick();
    want_count(0);

    // Load miss against a 3-cycle-late ack.
    tick(); ack_lat = 3; rd_val = 16'h5A5A;
    cpu_ld(16'h0040); want_stall(1); exp_rd(16'h0040, 16'h5A5A);
    repeat (4) begin tick(); want_stall(1); end
    tick(); want_stall(0);
    tick(); cpu_idle();

    // Fill all entries, then a fifth store waits for the first drain.
    ack_en = 1'b0; ack_lat = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); cpu_st(16'h0100 + 16'(2 * i), 16'hD000 + 16'(i)); want_stall(0);
      exp_wr(16'h0100 + 16'(2 * i), 16'hD000 + 16'(i));
    end
    tick(); cpu_st(16'h0108, 16'hD004); want_stall(1); want_count(4); exp_wr(16'h0108, 16'hD004);
    tick(); want_stall(1); want_count(4);
    tick(); ack_en = 1'b1; want_stall(1); want_count(4);
    tick(); want_stall(0); want_count(3);
    tick(); cpu_idle(); want_count(4);
    repeat (12) tick();
    want_count(0);

    // Load miss behind a pending write.
    tick(); ack_en = 1'b0; rd_val = 16'h7777;
    cpu_st(16'h0050, 16'h1234); want_stall(0); exp_wr(16'h0050, 16'h1234);
    tick(); cpu_idle();
    tick(); cpu_ld(16'h0060); want_stall(1); exp_rd(16'h0060, 16'h7777);
    tick(); want_stall(1);
    tick(); ack_en = 1'b1; want_stall(1);
    tick(); want_stall(1);
    tick(); want_stall(1);
    tick(); want_stall(0);
    tick(); cpu_idle(); want_count(0);

    // Reset during a read with two stores still buffered.
    tick(); ack_en = 1'b0;
    cpu_st(16'h0070, 16'h0001); want_stall(0); exp_wr(16'h0070, 16'h0001);
    tick(); cpu_st(16'h0072, 16'h0002);
    tick(); cpu_st(16'h0074, 16'h0003);
    tick(); cpu_ld(16'h0080); want_stall(1); want_count(3);
    tick(); ack_en = 1'b1; want_stall(1);
    tick(); ack_en = 1'b0; want_stall(1); want_count(2);
    tick(); want_stall(1); want_count(2);
    tick(); reset = 1'b0; pr_zero_en = 1'b1;
    tick(); cpu_idle(); pr_zero_en = 1'b1;
    tick(); reset = 1'b1; stale = 1'b1; pr_zero_en = 1'b1;
    tick(); stale = 1'b0; pr_zero_en = 1'b1;
    tick(); ack_en = 1'b1;
    cpu_st(16'h0090, 16'hABCD); want_stall(0); want_count(0); exp_wr(16'h0090, 16'hABCD);
    tick(); cpu_idle(); want_count(1);
    repeat (6) tick();
    want_count(0);
    tick(); done = 1'b1;
  end
endmodule
